mem_stage_dcache: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and a slow external data memory.
- Takes the MEM-stage request (ALU result as address, store value, MEM_read, MEM_write). Returns load data and a ready flag that the pipeline uses to freeze the stages while a miss or write-through is outstanding.
- External memory is reached through a request/acknowledge handshake of arbitrary latency.

---
 rtl/mem_stage_dcache.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read hits complete in the same cycle. Read misses and all stores go through a
// req/ack handshake with slow external memory while the pipeline is frozen
// (ready=0). Each miss or store finishes with a one-cycle response.
module mem_stage_dcache #(
  parameter int INDEX_BITS = 6,
  parameter int HIT_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_read,
  input  logic                 MEM_write,
  input  logic [31:0]          address,
  input  logic [31:0]          ST_value,
  output logic [31:0]          MEM_out,
  output logic                 ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic [HIT_CNT_W-1:0] hit_count,
  output logic [HIT_CNT_W-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, RESP} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [HIT_CNT_W-1:0]   hit_q;
  logic [HIT_CNT_W-1:0]   miss_q;

  logic [INDEX_BITS-1:0]  idx_in, idx_q;
  logic [TAG_W-1:0]       tag_in, tag_q;
  logic                   rd_req, wr_req, rd_hit, wr_line_hit;
  logic                   fill_en, upd_en;
  logic [1:0]             unused_addr_bits;

  // Byte offset of the incoming address is irrelevant for word accesses.
  assign unused_addr_bits = address[1:0];

  assign idx_in = address[INDEX_BITS+1:2];
  assign tag_in = address[31:INDEX_BITS+2];
  assign idx_q  = addr_q[INDEX_BITS+1:2];
  assign tag_q  = addr_q[31:INDEX_BITS+2];

  // A simultaneous read and write is handled purely as a store.
  assign wr_req = MEM_write;
  assign rd_req = MEM_read & ~MEM_write;
  assign rd_hit = valid_q[idx_in] && (tag_mem[idx_in] == tag_in);

  // Stores only refresh a line that already holds the same word (no allocate).
  assign wr_line_hit = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
  assign fill_en     = (state_q == RD_MISS) && mem_ack;
  assign upd_en      = (state_q == WR_MEM) && mem_ack && wr_line_hit;

  assign mem_read   = (state_q == RD_MISS);
  assign mem_write  = (state_q == WR_MEM);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Next state, ready and load data; hits are answered combinationally.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    MEM_out = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR_MEM;
        end else if (rd_req) begin
          if (rd_hit) begin
            ready   = 1'b1;
            MEM_out = data_mem[idx_in];
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: if (mem_ack) state_d = RESP;
      WR_MEM:  if (mem_ack) state_d = RESP;
      RESP: begin
        ready   = 1'b1;
        MEM_out = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits, request capture, response latch and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (wr_req) begin
          addr_q  <= {address[31:2], 2'b00};
          wdata_q <= ST_value;
        end else if (rd_req && rd_hit) begin
          hit_q <= hit_q + 1'b1;
        end else if (rd_req) begin
          addr_q <= {address[31:2], 2'b00};
          miss_q <= miss_q + 1'b1;
        end
      end
      if (fill_en) begin
        valid_q[idx_q] <= 1'b1;
        rdata_q        <= mem_rdata;
      end
      if ((state_q == WR_MEM) && mem_ack) begin
        rdata_q <= 32'h0;
      end
    end
  end

  // Tag and data storage; contents need no reset because valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= mem_rdata;
    end else if (upd_en) begin
      data_mem[idx_q] <= wdata_q;
    end
  end

endmodule
